program_loader: RTL



---
 rtl/program_loader_if.sv | 26 ++
 rtl/program_loader.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/program_loader_if.sv
// Host byte link plus main-memory write port and cpu-release status of the loader.
interface program_loader_if;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        restart;
    logic        in_ready;
    logic        write_enable;
    logic [31:0] write_address;
    logic [31:0] write_data;
    logic        hold_cpu;
    logic        done;
    logic        error;
    logic [31:0] words_loaded;

    modport master (
        output in_valid, in_data, restart,
        input  in_ready, write_enable, write_address, write_data,
        input  hold_cpu, done, error, words_loaded
    );

    modport slave (
        input  in_valid, in_data, restart,
        output in_ready, write_enable, write_address, write_data,
        output hold_cpu, done, error, words_loaded
    );
endinterface

// File: rtl/program_loader.sv
// Boot loader: little-endian byte stream -> word writes into main memory, holds cpu until done.
// Optional trailing 32-bit modular checksum word when LOADER_CHECKSUM_EN is defined.
module program_loader #(
    parameter int unsigned DEPTH     = 2048,
    parameter logic [31:0] BASE_ADDR = 32'd0
) (
    input logic             clk,
    input logic             rst,
    program_loader_if.slave bus
);
    typedef enum logic [2:0] {
        S_HDR, S_DATA, S_CSUM, S_DONE, S_ERROR
    } state_t;

    localparam logic [31:0] L_DEPTH = 32'(DEPTH);
`ifdef LOADER_CHECKSUM_EN
    localparam state_t S_END = S_CSUM;
`else
    localparam state_t S_END = S_DONE;
`endif

    state_t      r_state;
    logic [1:0]  r_byte_idx;
    logic [23:0] r_shift;
    logic [31:0] r_count;
    logic        r_in_ready;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_hold;
    logic        r_done;
    logic        r_err;
    logic [31:0] r_words;
`ifdef LOADER_CHECKSUM_EN
    logic [31:0] r_csum;
`endif

    state_t      w_next;
    logic        w_accept;
    logic        w_last_byte;
    logic [31:0] w_word;
    logic [31:0] w_words_nxt;
    logic        w_restart;

    assign w_accept    = bus.in_valid & r_in_ready;
    assign w_last_byte = w_accept & (r_byte_idx == 2'd3);
    assign w_word      = {bus.in_data, r_shift};
    assign w_words_nxt = r_words + 32'd1;
    assign w_restart   = bus.restart &
                         ((r_state == S_DONE) | (r_state == S_ERROR));

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_HDR: begin
                if (w_last_byte) begin
                    if (w_word == 32'd0)
                        w_next = S_END;
                    else if (w_word > L_DEPTH)
                        w_next = S_ERROR;
                    else
                        w_next = S_DATA;
                end
            end
            S_DATA: begin
                if (w_last_byte && (w_words_nxt == r_count))
                    w_next = S_END;
            end
`ifdef LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (w_last_byte)
                    w_next = (w_word == r_csum) ? S_DONE : S_ERROR;
            end
`endif
            S_DONE, S_ERROR: begin
                if (bus.restart)
                    w_next = S_HDR;
            end
            default: w_next = S_HDR;
        endcase
    end

    // Status flags are registered from the next state so they move on the entering edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_HDR;
            r_byte_idx <= 2'd0;
            r_shift    <= 24'd0;
            r_count    <= 32'd0;
            r_in_ready <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= 32'd0;
            r_wdata    <= 32'd0;
            r_hold     <= 1'b1;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_words    <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
            r_csum     <= 32'd0;
`endif
        end else begin
            r_state    <= w_next;
            r_in_ready <= (w_next == S_HDR) | (w_next == S_DATA) |
                          (w_next == S_CSUM);
            r_hold     <= (w_next != S_DONE);
            r_done     <= (w_next == S_DONE);
            r_err      <= (w_next == S_ERROR);
            r_we       <= 1'b0;
            if (w_accept) begin
                r_shift    <= w_word[31:8];
                r_byte_idx <= r_byte_idx + 2'd1;
            end
            if ((r_state == S_HDR) && w_last_byte)
                r_count <= w_word;
            if ((r_state == S_DATA) && w_last_byte) begin
                r_we    <= 1'b1;
                r_addr  <= BASE_ADDR + r_words;
                r_wdata <= w_word;
                r_words <= w_words_nxt;
`ifdef LOADER_CHECKSUM_EN
                r_csum  <= r_csum + w_word;
`endif
            end
            if (w_restart) begin
                r_words    <= 32'd0;
                r_byte_idx <= 2'd0;
                r_shift    <= 24'd0;
`ifdef LOADER_CHECKSUM_EN
                r_csum     <= 32'd0;
`endif
            end
        end
    end

    assign bus.in_ready      = r_in_ready;
    assign bus.write_enable  = r_we;
    assign bus.write_address = r_addr;
    assign bus.write_data    = r_wdata;
    assign bus.hold_cpu      = r_hold;
    assign bus.done          = r_done;
    assign bus.error         = r_err;
    assign bus.words_loaded  = r_words;
endmodule
